// File: rtl/multu_seq.sv
// Sequential radix-2 shift-add multiplier for MULT/MULTU, result delivered on {hi,lo}.
// Optional macro MULTU_EARLY_TERM_EN: leave CALC once the remaining multiplier bits are all zero.
module multu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signmul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   msh;
  logic [WIDTH-1:0] mb;
  logic [CW-1:0]   cnt;
  logic            neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    prod;
  logic             last_iter;

  assign state_dbg = state;

  // Handshake: start is accepted only in IDLE (busy low); done pulses for one
  // cycle when hi/lo update, and a start in that same cycle is accepted.
  always_comb begin
    a_mag     = (signmul && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag     = (signmul && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    acc_next  = mb[0] ? (acc + msh) : acc;
    prod      = neg ? (~acc + PW'(1)) : acc;
`ifdef MULTU_EARLY_TERM_EN
    last_iter = (mb[WIDTH-1:1] == '0);
`else
    last_iter = (cnt == CW'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      acc   <= '0;
      msh   <= '0;
      mb    <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            msh   <= {{WIDTH{1'b0}}, a_mag};
            mb    <= b_mag;
            neg   <= signmul & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          // msh tracks the multiplicand already shifted by the iteration count
          acc <= acc_next;
          msh <= msh << 1;
          mb  <= mb >> 1;
          cnt <= cnt + CW'(1);
          if (last_iter) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= prod;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multu_seq.sv
// Randomized bench for multu_seq against an arithmetic reference model of the product and latency.
module tb_multu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signmul;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  multu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signmul(signmul),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] ex, ey;
    ex = s ? {{32{x[31]}}, x} : {32'b0, x};
    ey = s ? {{32{y[31]}}, y} : {32'b0, y};
    return ex * ey;
  endfunction

  function automatic int ref_lat(input logic [31:0] y, input logic s);
    logic [31:0] m;
    int k;
    m = (s && y[31]) ? (32'd0 - y) : y;
    k = W;
`ifdef MULTU_EARLY_TERM_EN
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
`endif
    return k + 2;
  endfunction

  // Starts in the current cycle; returns in the done cycle so the next call starts there.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input string tag, input int restart_at);
    int n;
    int lat;
    bit hs_ok;
    bit got_done;
    logic [63:0] e;
    hs_ok    = 1'b1;
    got_done = 1'b0;
    exp_q.push_back(ref_mul(x, y, s));
    lat = ref_lat(y, s);
    a = x; b = y; signmul = s; start = 1'b1;
    n = 0;
    while (!got_done && n < 200) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (n == restart_at) begin
        start = 1'b1; a = 32'd1; b = 32'd1; signmul = ~s;
      end else if (n > 1) begin
        a = $urandom; b = $urandom; signmul = 1'($urandom_range(0, 1));
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        if (busy !== 1'b0) hs_ok = 1'b0;
      end else if (busy !== 1'b1) begin
        hs_ok = 1'b0;
      end
    end
    e = exp_q.pop_front();
    if (!got_done) begin
      check({tag, " timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, " lat"}, 64'(n), 64'(lat));
      check({tag, " prod"}, {hi, lo}, e);
      check({tag, " busy"}, 64'(hs_ok), 64'd1);
    end
  endtask

  initial begin
    bit seen;
    logic [31:0] x, y;
    rst = 1'b1; start = 1'b0; signmul = 1'b0; a = '0; b = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst state", 64'(state_dbg), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax", -1);
    @(posedge clk); #1;
    check("umax done pulse", 64'(done), 64'd0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "s_m1x1", -1);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "u_m1x1", -1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "minsq", -1);
    run_op(32'h8000_0000, 32'h0000_0002, 1'b1, "minx2", -1);
    run_op(32'd7, 32'd6, 1'b0, "ignore", 10);
    run_op(32'd9, 32'd3, 1'b0, "9x3", -1);
    run_op(32'h1234_5678, 32'd0, 1'b0, "bzero", -1);
    run_op(32'd5, 32'h8000_0000, 1'b0, "bmsb", -1);

    // Abort mid-operation with reset
    run_op(32'd2, 32'h8000_0001, 1'b0, "pre", -1);
    a = $urandom; b = $urandom; start = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("abort quiet", 64'(seen), 64'd0);
    run_op(32'd3, 32'd5, 1'b0, "post", -1);

    for (int i = 0; i < 25; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: y = y >> $urandom_range(1, 31);
        1: x = 32'h8000_0000;
        2: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      run_op(x, y, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), -1);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
